// File: rtl/riscy_operand_reader.sv
// -----------------------------------------------------------------------------
// riscy_operand_reader
//
// Purpose:
//   Read side of the processor's architectural register file. It stores
//   writeback results, serves two-operand read requests from decode, and
//   keeps a per-register busy scoreboard so that a read never sees a stale
//   value (RAW) and two in-flight writers never target the same register
//   (WAW). A writeback landing in the same cycle as a read is forwarded
//   straight to the operand. Operands leave through a one-entry registered
//   output stage with a valid/ready handshake.
//
// Parameters:
//   WIDTH   data width of each register
//   ADDR_W  register address width; the file holds 2**ADDR_W registers
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RST_N      asynchronous active-low reset
//   WB_EN      writeback write strobe (never stalled)
//   WB_ADDR    writeback destination register
//   WB_DATA    writeback data
//   REQ_VALID  decode presents a read request
//   REQ_READY  request is accepted this cycle (independent of REQ_VALID)
//   RS1, RS2   source register addresses
//   RD         destination register claimed by the request
//   RD_WE      request will later write RD
//   OUT_VALID  OP1/OP2 hold a valid operand pair
//   OUT_READY  consumer takes the operand pair
//   OP1, OP2   source 1 / source 2 operand values
//
// Register 0 reads as zero, ignores writes and is never busy.
// -----------------------------------------------------------------------------
module riscy_operand_reader #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              WB_EN,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [WIDTH-1:0]  WB_DATA,

    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic [ADDR_W-1:0] RD,
    input  logic              RD_WE,

    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WIDTH-1:0]  OP1,
    output logic [WIDTH-1:0]  OP2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             out_valid_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;

    // -------------------------------------------------------------------------
    // Writeback decode and bypass
    // -------------------------------------------------------------------------
    logic             wb_hit;      // a real write this cycle (not to x0)
    logic             rs1_byp;
    logic             rs2_byp;
    logic             rd_clr;      // RD's busy bit is being cleared by WB now
    logic [WIDTH-1:0] op1_val;
    logic [WIDTH-1:0] op2_val;

    assign wb_hit  = WB_EN && (WB_ADDR != ZERO_ADDR);
    assign rs1_byp = wb_hit && (RS1 == WB_ADDR);
    assign rs2_byp = wb_hit && (RS2 == WB_ADDR);
    assign rd_clr  = wb_hit && (RD == WB_ADDR);

    // Operand selection: x0 is hard zero, then same-cycle writeback, then the
    // stored value. Self-reference (RS == RD) naturally reads the old value
    // because busy[RD] is only set at the accepting edge.
    always_comb begin
        op1_val = regs[RS1];
        if (RS1 == ZERO_ADDR) begin
            op1_val = '0;
        end else if (rs1_byp) begin
            op1_val = WB_DATA;
        end
    end

    always_comb begin
        op2_val = regs[RS2];
        if (RS2 == ZERO_ADDR) begin
            op2_val = '0;
        end else if (rs2_byp) begin
            op2_val = WB_DATA;
        end
    end

    // -------------------------------------------------------------------------
    // Hazard detection and request handshake
    // -------------------------------------------------------------------------
    logic raw1;
    logic raw2;
    logic waw;
    logic hazard;
    logic out_free;
    logic accept;

    // A source being written back this cycle is forwarded, so it is not a
    // hazard even though its busy bit is still set until the edge.
    assign raw1   = busy[RS1] && !rs1_byp;
    assign raw2   = busy[RS2] && !rs2_byp;
    assign waw    = RD_WE && busy[RD] && !rd_clr;
    assign hazard = raw1 || raw2 || waw;

    // The output slot can take a new pair if it is empty or being drained.
    assign out_free = !out_valid_q || OUT_READY;

    // Held low while reset is asserted so nothing is handed over during reset.
    assign REQ_READY = RST_N && !hazard && out_free;
    assign accept    = REQ_VALID && REQ_READY;

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    // NOTE: every combinational output is given a default before any
    // conditional assignment, so no path can leave it unassigned and infer a
    // latch.
    always_comb begin
        busy_nxt = busy;
        if (wb_hit) begin
            busy_nxt[WB_ADDR] = 1'b0;
        end
        // Applied after the clear: when the same edge clears and sets a bit,
        // the new claim wins.
        if (accept && RD_WE && (RD != ZERO_ADDR)) begin
            busy_nxt[RD] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    // NOTE: the storage array is cleared by reset because the register file
    // must read as zero after reset; this forces a flop-based implementation
    // rather than a RAM macro, which is acceptable at this depth.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[WB_ADDR] <= WB_DATA;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard and output stage
    // -------------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy        <= '0;
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
        end else begin
            busy <= busy_nxt;
            if (accept) begin
                out_valid_q <= 1'b1;
                op1_q       <= op1_val;
                op2_q       <= op2_val;
            end else if (out_valid_q && OUT_READY) begin
                // Drained with nothing new behind it; operands keep their
                // last value but are no longer valid.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OP1       = op1_q;
    assign OP2       = op2_q;

endmodule

// File: tb/tb_riscy_operand_reader.sv
// -----------------------------------------------------------------------------
// tb_riscy_operand_reader
//
// Drives riscy_operand_reader from a table of per-cycle input records, each
// carrying the expected REQ_READY and OUT_VALID for that cycle. Operand values
// are predicted by a small register-file model when a request is accepted,
// queued, and compared whenever the DUT presents OUT_VALID.
// -----------------------------------------------------------------------------
module tb_riscy_operand_reader;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              WB_EN;
    logic [ADDR_W-1:0] WB_ADDR;
    logic [WIDTH-1:0]  WB_DATA;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [ADDR_W-1:0] RS1;
    logic [ADDR_W-1:0] RS2;
    logic [ADDR_W-1:0] RD;
    logic              RD_WE;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [WIDTH-1:0]  OP1;
    logic [WIDTH-1:0]  OP2;

    riscy_operand_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WB_EN     (WB_EN),
        .WB_ADDR   (WB_ADDR),
        .WB_DATA   (WB_DATA),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .RS1       (RS1),
        .RS2       (RS2),
        .RD        (RD),
        .RD_WE     (RD_WE),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OP1       (OP1),
        .OP2       (OP2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string             name;
        logic              wb_en;
        logic [ADDR_W-1:0] wb_addr;
        logic [WIDTH-1:0]  wb_data;
        logic              req_valid;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              rd_we;
        logic              out_ready;
        logic              exp_ready;
        logic              exp_ov;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
    } ops_t;

    ops_t             sb[$];
    logic [WIDTH-1:0] model_rf [DEPTH];
    vec_t             tbl[$];
    int               checks   = 0;
    int               failures = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic wb_en,
                                input logic [ADDR_W-1:0] wb_addr,
                                input logic [WIDTH-1:0] wb_data,
                                input logic req_valid,
                                input logic [ADDR_W-1:0] rs1,
                                input logic [ADDR_W-1:0] rs2,
                                input logic [ADDR_W-1:0] rd,
                                input logic rd_we, input logic out_ready,
                                input logic exp_ready, input logic exp_ov);
        vec_t v;
        v.name = name;       v.wb_en = wb_en;         v.wb_addr = wb_addr;
        v.wb_data = wb_data; v.req_valid = req_valid; v.rs1 = rs1;
        v.rs2 = rs2;         v.rd = rd;               v.rd_we = rd_we;
        v.out_ready = out_ready; v.exp_ready = exp_ready; v.exp_ov = exp_ov;
        return v;
    endfunction

    // Expected operand value: x0 is zero, a same-cycle writeback forwards.
    function automatic logic [WIDTH-1:0] model_op(input logic [ADDR_W-1:0] a,
                                                  input vec_t v);
        if (a == 0) return '0;
        if (v.wb_en && v.wb_addr == a) return v.wb_data;
        return model_rf[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_rf[i] = '0;
    endtask

    // Drive one cycle's inputs, check the combinational/registered outputs,
    // run the scoreboard, then advance one clock.
    task automatic apply(input vec_t v);
        ops_t e;
        WB_EN = v.wb_en;         WB_ADDR = v.wb_addr; WB_DATA = v.wb_data;
        REQ_VALID = v.req_valid; RS1 = v.rs1;         RS2 = v.rs2;
        RD = v.rd;               RD_WE = v.rd_we;     OUT_READY = v.out_ready;
        #1;
        check({v.name, " req_ready"}, REQ_READY, v.exp_ready);
        check({v.name, " out_valid"}, OUT_VALID, v.exp_ov);
        if (OUT_VALID) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s spurious: got OUT_VALID=1 expected no pending operands", v.name);
            end else begin
                check({v.name, " op1"}, OP1, sb[0].op1);
                check({v.name, " op2"}, OP2, sb[0].op2);
                if (v.out_ready) void'(sb.pop_front());
            end
        end
        if (v.req_valid && v.exp_ready) begin
            e.op1 = model_op(v.rs1, v);
            e.op2 = model_op(v.rs2, v);
            sb.push_back(e);
        end
        @(posedge CLK);
        if (v.wb_en && v.wb_addr != 0) model_rf[v.wb_addr] = v.wb_data;
        @(negedge CLK);
    endtask

    initial begin
        // Table: name, wb_en, wb_addr, wb_data, req_valid, rs1, rs2, rd, rd_we,
        //        out_ready, exp_ready, exp_ov
        // Basic read
        tbl.push_back(mk("wb_x3",      1, 3, 32'h0000_00AA, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("wb_x4",      1, 4, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("rd_3_4",     0, 0, 32'h0,         1, 3, 4, 0, 0, 1, 1, 0));
        tbl.push_back(mk("rd_3_4_out", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 1));
        // RAW stall then bypass
        tbl.push_back(mk("claim_x7",   0, 0, 32'h0,         1, 0, 0, 7, 1, 1, 1, 0));
        tbl.push_back(mk("raw_st1",    0, 0, 32'h0,         1, 7, 3, 0, 0, 1, 0, 1));
        tbl.push_back(mk("raw_st2",    0, 0, 32'h0,         1, 7, 3, 0, 0, 1, 0, 0));
        tbl.push_back(mk("raw_st3",    0, 0, 32'h0,         1, 7, 3, 0, 0, 1, 0, 0));
        tbl.push_back(mk("raw_byp",    1, 7, 32'hDEAD_BEEF, 1, 7, 3, 0, 0, 1, 1, 0));
        tbl.push_back(mk("raw_out",    0, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 1));
        // Register 0
        tbl.push_back(mk("wb_x0",      1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("x0_rd0",     0, 0, 32'h0,         1, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk("x0_again",   0, 0, 32'h0,         1, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk("x0_out",     0, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 1));
        // WAW stall, then same-edge clear/set on x9
        tbl.push_back(mk("claim_x9",   0, 0, 32'h0,         1, 0, 0, 9, 1, 1, 1, 0));
        tbl.push_back(mk("waw_stall",  0, 0, 32'h0,         1, 3, 4, 9, 1, 1, 0, 1));
        tbl.push_back(mk("waw_setclr", 1, 9, 32'h0000_0099, 1, 3, 4, 9, 1, 1, 1, 0));
        tbl.push_back(mk("x9_raw1",    0, 0, 32'h0,         1, 9, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk("x9_raw2",    0, 0, 32'h0,         1, 9, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("x9_wb",      1, 9, 32'h1234_ABCD, 1, 9, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("x9_out",     0, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 1));
        // Self-reference reads the old value, then release x3
        tbl.push_back(mk("self_x3",    0, 0, 32'h0,         1, 3, 0, 3, 1, 1, 1, 0));
        tbl.push_back(mk("self_out",   0, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk("wb_x3_33",   1, 3, 32'h0000_0033, 0, 0, 0, 0, 0, 1, 1, 0));

        clear_model();
        WB_EN = 0; WB_ADDR = '0; WB_DATA = '0; REQ_VALID = 1; RS1 = '0;
        RS2 = '0; RD = '0; RD_WE = 0; OUT_READY = 1;
        RST_N = 1'b0;
        #12;
        check("reset req_ready", REQ_READY, 1'b0);
        check("reset out_valid", OUT_VALID, 1'b0);
        check("reset op1", OP1, '0);
        check("reset op2", OP2, '0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Output backpressure: held operands, then drain and refill back to back.
        apply(mk("bp_first",   0, 0, 32'h0, 1, 3, 4, 0, 0, 0, 1, 0));
        apply(mk("bp_hold1",   0, 0, 32'h0, 1, 4, 9, 0, 0, 0, 0, 1));
        apply(mk("bp_hold2",   0, 0, 32'h0, 1, 4, 9, 0, 0, 0, 0, 1));
        apply(mk("bp_release", 0, 0, 32'h0, 1, 4, 9, 0, 0, 1, 1, 1));
        apply(mk("bp_second",  0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 1));

        // Reset while an output is pending and x5 is claimed.
        apply(mk("pre_rst",    0, 0, 32'h0, 1, 0, 0, 5, 1, 0, 1, 0));
        REQ_VALID = 1; RS1 = 5; RS2 = 3; RD = '0; RD_WE = 0; OUT_READY = 0;
        RST_N = 1'b0;
        #1;
        check("mid_rst out_valid", OUT_VALID, 1'b0);
        check("mid_rst op1", OP1, '0);
        check("mid_rst op2", OP2, '0);
        check("mid_rst req_ready", REQ_READY, 1'b0);
        sb.delete();
        clear_model();
        @(negedge CLK);
        RST_N = 1'b1;
        apply(mk("post_rst_x5", 0, 0, 32'h0, 1, 5, 3, 0, 0, 1, 1, 0));
        apply(mk("post_rst_out", 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 1));

        #1;
        check("drain out_valid", OUT_VALID, 1'b0);
        check("drain pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
